// File: rtl/merger_arb_pkg.sv
// Shared types and constants for the merger lane arbiter.
package merger_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } arb_state_e;

  // Merger pipeline depth in advancing cycles.
  localparam int DEFAULT_DRAIN_CYCLES = 8;

  // A tuple with this key terminates a sorted run.
  localparam logic [31:0] TERM_KEY = 32'h0;

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set search: starting just above ptr_i and wrapping,
// returns the first requesting lane as one-hot and binary index.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [W-1:0] cand;

  // Walk offsets 1..N from the pointer; the nearest requester wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = W'((int'(ptr_i) + k) % N);
      if (!found_o && req_i[cand]) begin
        found_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/merger_lane_arbiter.sv
// Time-shares one bitonic merger among NUM_LANES lane pairs. A lane keeps
// the merger for a whole run (zero-key terminator seen on both A and B),
// then the pipeline drains, a flush pulse clears it, and the next lane in
// round-robin order is granted.
// Optional: MERGER_ARB_STATS_EN adds the o_runs_done completed-run counter.
//
// state | meaning
// IDLE  | no owner; pick next requesting lane after the pointer
// GRANT | lane owns merger; collecting A/B terminators
// DRAIN | grant held; counting advancing cycles until pipeline empty
// FLUSH | one-cycle flush pulse, grant dropped, pointer advanced
module merger_lane_arbiter
  import merger_arb_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int LANE_W       = 2,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_LANES-1:0] i_lane_req,
  input  logic                 i_term_a,
  input  logic                 i_term_b,
  input  logic                 i_fifo_out_ready,
  output logic [NUM_LANES-1:0] o_grant,
  output logic                 o_grant_valid,
  output logic [LANE_W-1:0]    o_lane_idx,
  output logic                 o_flush
`ifdef MERGER_ARB_STATS_EN
  ,
  output logic [15:0]          o_runs_done
`endif
);

  arb_state_e           state_q;
  logic [NUM_LANES-1:0] grant_q;
  logic                 grant_valid_q;
  logic [LANE_W-1:0]    lane_idx_q;
  logic                 flush_q;
  logic [LANE_W-1:0]    ptr_q;
  logic                 term_a_q, term_b_q;
  logic                 term_a_d, term_b_d;
  logic [7:0]           cnt_q;

  logic [NUM_LANES-1:0] pick_grant;
  logic [LANE_W-1:0]    pick_idx;
  logic                 pick_found;

  rr_pick #(
    .N (NUM_LANES),
    .W (LANE_W)
  ) u_rr_pick (
    .req_i   (i_lane_req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Sticky terminator flags including this cycle's pulses, so both sides
  // arriving together still end the run.
  always_comb begin
    term_a_d = term_a_q | i_term_a;
    term_b_d = term_b_q | i_term_b;
  end

`ifdef MERGER_ARB_STATS_EN
  logic [15:0] runs_q;

  // Completed-run counter, bumped once per FLUSH cycle; wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) runs_q <= '0;
    else if (state_q == ST_FLUSH) runs_q <= runs_q + 16'd1;
  end

  assign o_runs_done = runs_q;
`endif

  // Arbitration FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      lane_idx_q    <= '0;
      flush_q       <= 1'b0;
      ptr_q         <= LANE_W'(NUM_LANES - 1);
      term_a_q      <= 1'b0;
      term_b_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_q       <= pick_grant;
            grant_valid_q <= 1'b1;
            lane_idx_q    <= pick_idx;
            state_q       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          term_a_q <= term_a_d;
          term_b_q <= term_b_d;
          if (term_a_d && term_b_d) begin
            cnt_q   <= 8'(DRAIN_CYCLES - 1);
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Only advancing cycles move data out of the merger.
          if (i_fifo_out_ready) begin
            if (cnt_q == 8'd0) begin
              flush_q       <= 1'b1;
              grant_q       <= '0;
              grant_valid_q <= 1'b0;
              state_q       <= ST_FLUSH;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        ST_FLUSH: begin
          ptr_q    <= lane_idx_q;
          term_a_q <= 1'b0;
          term_b_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_grant       = grant_q;
  assign o_grant_valid = grant_valid_q;
  assign o_lane_idx    = lane_idx_q;
  assign o_flush       = flush_q;

endmodule
